// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream width converter: one DW_OUT*SCALE word in, SCALE DW_OUT beats out.
// A new word can be loaded in the same cycle its predecessor's last beat is read, so there are no bubbles.
module stream_downsizer #(
    parameter int DW_OUT    = 8,
    parameter int SCALE     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW_OUT*SCALE-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [DW_OUT-1:0]       m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    // SCALE=1 still needs a legal 1-bit beat counter.
    localparam int IDX_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SCALE - 1);

    logic [DW_OUT*SCALE-1:0] r_data;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_full;
    logic                    r_last;
    logic                    r_rst;

    logic                    w_wr;
    logic                    w_rd;
    logic                    w_wrap;
    logic [IDX_W-1:0]        w_sel;

    assign w_wrap    = (r_idx == LAST_IDX);
    assign w_rd      = r_full & m_ready_i;
    assign s_ready_o = ~r_rst & (~r_full | (w_rd & w_wrap));
    assign w_wr      = s_valid_i & s_ready_o;

    assign w_sel     = MSB_FIRST ? (LAST_IDX - r_idx) : r_idx;
    assign m_data_o  = r_data[int'(w_sel)*DW_OUT +: DW_OUT];
    assign m_valid_o = r_full;
    assign m_last_o  = r_full & r_last & w_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_idx  <= '0;
            r_last <= 1'b0;
            r_rst  <= 1'b1;
        end else begin
            r_rst <= 1'b0;
            if (w_wr) begin
                r_full <= 1'b1;
                r_idx  <= '0;
                r_last <= s_last_i;
            end else if (w_rd && w_wrap) begin
                r_full <= 1'b0;
                r_idx  <= '0;
            end else if (w_rd) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // The data register carries no reset; its contents only matter while r_full is set.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_data <= s_data_i;
        end
    end

endmodule

// File: doc/stream_downsizer.md
Name: stream_downsizer

Overview:
- Width converter: accepts one wide stream word of DW_OUT*SCALE bits and emits it as SCALE narrow beats of DW_OUT bits each.
- Sits downstream of the wide datapath, for example after a stream_upsizer plus wide-word processing, and feeds a narrow sink such as a UART, SPI or DMA byte lane.
- Uses a valid/ready handshake on both sides.
- Carries an end-of-packet flag through the conversion.
- Sustains full narrow-side throughput with no bubble between consecutive wide words.

Parameters:
- DW_OUT, 8, width of one output beat in bits (must be >= 1).
- SCALE, 4, number of output beats per input word (must be >= 1).
- MSB_FIRST, 0: 0 emits the lowest slice first, 1 emits the highest slice first.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- s_data_i  input  DW_OUT*SCALE  wide input word
- s_last_i  input  1  input word is the last of its packet
- s_valid_i  input  1  input word valid
- s_ready_o  output  1  block accepts the input word this cycle
- m_data_o  output  DW_OUT  current narrow beat
- m_last_o  output  1  this beat is the final beat of a packet
- m_valid_o  output  1  narrow beat valid
- m_ready_i  input  1  sink accepts the beat

Behaviour:
- Internal state:
  - data register, DW_OUT*SCALE bits
  - beat index idx, width max(1, clog2(SCALE)), range 0..SCALE-1
  - full flag
  - last_r flag
  - rst_r flag
- Definitions:
  - wr = s_valid_i & s_ready_o
  - rd = m_valid_o & m_ready_i
  - wrap = (idx == SCALE-1)
- Output side:
  - m_valid_o = full.
  - m_data_o is slice k of data, where k = idx if MSB_FIRST=0, else SCALE-1-idx. Slice k is bits [k*DW_OUT +: DW_OUT].
  - m_last_o = full & last_r & wrap. Intermediate beats never assert last.
- Input side:
  - s_ready_o = !rst_r & (!full | (rd & wrap)). The ready-to-ready path is combinational, which is intended.
- Per cycle, in priority order:
  - wr: data <= s_data_i, last_r <= s_last_i, full <= 1, idx <= 0. This covers both the empty case and a load in the same cycle as the last-beat read.
  - else rd & wrap: full <= 0, idx <= 0.
  - else rd: idx <= idx+1.
  - else: hold all state.
- Latency:
  - First narrow beat appears the cycle after wr.
  - One wide word drains in SCALE cycles when m_ready_i is held high.
  - Back-to-back words with continuous ready produce a contiguous narrow stream.
- Backpressure:
  - m_ready_i low holds m_data_o, m_last_o and idx stable.
  - m_valid_o never drops once asserted until the beat is accepted.
- SCALE=1:
  - wrap is always true, so the block acts as a one-deep registered pipeline stage with full throughput.
- Reset:
  - full=0, idx=0, last_r=0, rst_r=1.
  - m_valid_o=0 and m_last_o=0 during reset.
  - s_ready_o=0 during reset and for exactly one cycle after rst deasserts; rst_r clears on the first non-reset edge.
  - Data contents are don't-care.
  - Reset mid-word discards the remaining beats. No partial beat is emitted afterwards.
- Protocol assumptions on the upstream side: s_data_i and s_last_i are stable while s_valid_i is high and not yet accepted. The block does not check this.

Decomposition:
- No shared package required.
- The idx width function max(1, clog2(SCALE)) is a local localparam, so SCALE=1 still yields a legal 1-bit counter.
- Single flat module; no sub-module is natural.
- The slice mux is an indexed part-select, not a separate block.

Test Plan (DW_OUT=8, SCALE=4 unless noted):
- Reset: hold rst 3 cycles, then release -> s_ready_o=0 in the first post-reset cycle, 1 in the next; m_valid_o=0 throughout.
- Single word: s_data_i=0x44332211, s_last_i=1, m_ready_i=1 -> beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles; m_last_o=1 only with 0x44; s_ready_o=1 in the 0x44 cycle.
- Back-to-back: words 0x44332211 then 0x88776655, s_valid_i held high, m_ready_i=1 -> 8 contiguous beats 0x11..0x88 with no gap; second word accepted in the same cycle 0x44 is read.
- Backpressure: toggle m_ready_i 1,0,0,1,... during a word -> m_data_o held through stalls; no beat lost or duplicated; output sequence identical to the no-stall case.
- MSB_FIRST=1, word 0xAABBCCDD -> beats 0xAA, 0xBB, 0xCC, 0xDD.
- Reset mid-word: assert rst after beat 0x22 of 0x44332211 -> m_valid_o=0 next cycle; the next word 0x0D0C0B0A streams 0x0A first.
